rom_pack_dma: RTL and testbench
===============================

ROM_PACK_DMA -- requirements
Module: rom_pack_dma

Interface
REQ-001 SHALL have parameter ROM_ADDR_WIDTH, default 16, ROM address width.
REQ-002 SHALL have parameter ROM_DATA_WIDTH, default 8, ROM data width.
REQ-003 SHALL have parameter PACK, default 4, number of ROM reads per FIFO word, range 1..8.
REQ-004 SHALL have parameter WAIT_CYC, default 8, number of cycles per ROM access, at least 1.
REQ-005 SHALL have parameter FIFO_DATA_WIDTH, default ROM_DATA_WIDTH*PACK, the FIFO word width.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- reset_n  in  1  reset. One clock; reset is synchronous and active-low.
- start  in  1  launches a batch; ignored while busy.
- abort  in  1  cancels the batch in flight.
- cfg_base_addr  in  ROM_ADDR_WIDTH  first ROM address.
- cfg_num_reads  in  ROM_ADDR_WIDTH  number of ROM reads.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse when a batch completes.
- fifo_data_in  out  FIFO_DATA_WIDTH  packed word.
- fifo_push  out  1  push strobe.
- fifo_full  in  1  FIFO full.
- rom_rd_addr  out  ROM_ADDR_WIDTH  ROM address.
- CE_bar, OE_bar, WE_bar  out  1 each  ROM controls, active-low.
- rom_rd_data  in  ROM_DATA_WIDTH  ROM data.

Function
REQ-007 SHALL implement the FSM states IDLE, ACCESS, PUSH and DONE.
REQ-008 SHALL, in IDLE with start high, latch cfg_base_addr and cfg_num_reads, clear the read index and pack register, and go to DONE if cfg_num_reads==0, else to ACCESS.
REQ-009 SHALL, in ACCESS, hold CE_bar=0, OE_bar=0, WE_bar=1 and rom_rd_addr=base+index (mod 2^ROM_ADDR_WIDTH) stable for exactly WAIT_CYC cycles; in every other state these outputs SHALL be CE_bar=OE_bar=WE_bar=1 and rom_rd_addr=0.
REQ-010 SHALL, in the last ACCESS cycle, capture rom_rd_data into lane (index mod PACK), with lane 0 in the LSBs, and increment the index.
REQ-011 SHALL, after that capture, go to PUSH if the lane was PACK-1 or the read was the last one; otherwise it SHALL return to ACCESS with no gap cycle.
REQ-012 SHALL, in PUSH, assert fifo_push combinationally when fifo_full==0 and abort==0, with fifo_data_in equal to the pack register; a partial final word SHALL have zeros in its unused lanes.
REQ-013 SHALL stay in PUSH while fifo_full is high; after an accepted push it SHALL clear the pack register and go to ACCESS if reads remain, else to DONE.
REQ-014 SHALL, in DONE, assert done for one cycle and then go to IDLE.
REQ-015 SHALL, when abort is high in ACCESS or PUSH, go to IDLE on the next cycle with no push and no done pulse; abort takes priority over the push.
REQ-016 SHALL treat abort in IDLE or DONE as a no-op.
REQ-017 SHALL, when start and abort are both high in IDLE, let abort win so that no batch starts.
REQ-018 SHALL hold fifo_data_in at 0 when fifo_push is low.

Reset
REQ-019 SHALL, on reset, enter IDLE and drive busy=0, done=0, fifo_push=0, fifo_data_in=0, CE_bar=OE_bar=WE_bar=1 and rom_rd_addr=0, and clear the counters and pack register.
REQ-020 SHALL, on reset asserted mid-batch, abandon the batch with no push and no done pulse.

Configuration
REQ-021 SHALL, with ROM_DMA_PERF_EN defined, add output stall_cnt [15:0], counting PUSH cycles with fifo_full high, saturating at 16'hFFFF and cleared at an accepted start; its reset value SHALL be 0.
REQ-022 SHALL, without ROM_DMA_PERF_EN defined, omit the stall_cnt port and its logic, with all other behaviour unchanged.

Structure
REQ-023 SHALL place the state enum type and the default parameter constants in a shared package, rom_dma_pkg.
REQ-024 SHALL split the lane capture/clear/zero-fill logic into the sub-module rom_lane_packer.

Verification
REQ-025 SHALL cover: W=8, P=4, N=4, base=0x0010, fifo_full=0, start at cycle 0 -> addresses 0x10..0x13 each for 8 cycles, one push at cycle 33 of data {d3,d2,d1,d0}, done at cycle 34.
REQ-026 SHALL cover: N=6, P=4 -> two pushes; the second word is {0,0,d5,d4}; exactly one done pulse.
REQ-027 SHALL cover: fifo_full high for 5 cycles at the first PUSH -> fifo_push is held low for those 5 cycles, the push follows on the next cycle, and stall_cnt=5 with ROM_DMA_PERF_EN defined.
REQ-028 SHALL cover: base=0xFFFE, N=4, 16-bit address -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-029 SHALL cover: abort in the third ACCESS cycle of read 2 -> IDLE next cycle, no push, no done; a following start with N=0 -> done one cycle later with no ROM access.
REQ-030 SHALL cover: start pulsed while busy -> ignored, and the batch completes with the original configuration.

Source files
------------

// File: rtl/rom_dma_pkg.sv
// rom_dma_pkg: shared FSM state type, default parameters and lane-width helper for rom_pack_dma.
package rom_dma_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, PUSH, DONE} state_t;

    localparam int DEF_ROM_ADDR_WIDTH = 16;
    localparam int DEF_ROM_DATA_WIDTH = 8;
    localparam int DEF_PACK           = 4;
    localparam int DEF_WAIT_CYC       = 8;

    function automatic int lane_w(input int p);
        return p > 1 ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/rom_lane_packer.sv
// rom_lane_packer: assembles ROM bytes into a FIFO word; cleared words leave unused lanes zero.
module rom_lane_packer
    import rom_dma_pkg::*;
#(
    parameter int W  = DEF_ROM_DATA_WIDTH,
    parameter int P  = DEF_PACK,
    parameter int LW = lane_w(DEF_PACK)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           capture,
    input  logic [LW-1:0]  lane,
    input  logic [W-1:0]   data,
    output logic [W*P-1:0] word
);

    always_ff @(posedge clk) begin
        if (!reset_n || clear)
            word <= '0;
        else if (capture)
            word[lane*W +: W] <= data;
    end

endmodule

// File: rtl/rom_pack_dma.sv
// rom_pack_dma: reads a ROM range with fixed-latency accesses and pushes PACK bytes per FIFO word.
// Optional ROM_DMA_PERF_EN adds a saturating stall_cnt of PUSH cycles blocked by fifo_full.
module rom_pack_dma
    import rom_dma_pkg::*;
#(
    parameter int ROM_ADDR_WIDTH  = DEF_ROM_ADDR_WIDTH,
    parameter int ROM_DATA_WIDTH  = DEF_ROM_DATA_WIDTH,
    parameter int PACK            = DEF_PACK,
    parameter int WAIT_CYC        = DEF_WAIT_CYC,
    parameter int FIFO_DATA_WIDTH = ROM_DATA_WIDTH * PACK
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ROM_ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic [ROM_ADDR_WIDTH-1:0]  cfg_num_reads,
    output logic                       busy,
    output logic                       done,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_data_in,
    output logic                       fifo_push,
    input  logic                       fifo_full,
`ifdef ROM_DMA_PERF_EN
    output logic [15:0]                stall_cnt,
`endif
    output logic [ROM_ADDR_WIDTH-1:0]  rom_rd_addr,
    output logic                       CE_bar,
    output logic                       OE_bar,
    output logic                       WE_bar,
    input  logic [ROM_DATA_WIDTH-1:0]  rom_rd_data
);

    localparam int LW = lane_w(PACK);
    localparam int CW = WAIT_CYC > 1 ? $clog2(WAIT_CYC) : 1;

    state_t                       state, nxt;
    logic [ROM_ADDR_WIDTH-1:0]    base, num, idx;
    logic [LW-1:0]                lane;
    logic [CW-1:0]                wcnt;
    logic [ROM_DATA_WIDTH*PACK-1:0] pack_word;
    logic                         start_ok, last_acc, push_ok, word_end, reads_left;

    assign start_ok   = state == IDLE && start && !abort;
    assign last_acc   = state == ACCESS && !abort && wcnt == CW'(WAIT_CYC - 1);
    assign push_ok    = state == PUSH && !fifo_full && !abort;
    assign word_end   = lane == LW'(PACK - 1) || idx + 1'b1 == num;
    assign reads_left = idx != num;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start_ok) nxt = cfg_num_reads == '0 ? DONE : ACCESS;
            ACCESS:  nxt = abort ? IDLE : (last_acc && word_end) ? PUSH : ACCESS;
            PUSH:    nxt = abort ? IDLE : push_ok ? (reads_left ? ACCESS : DONE) : PUSH;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            base  <= '0;
            num   <= '0;
            idx   <= '0;
            lane  <= '0;
            wcnt  <= '0;
        end else begin
            state <= nxt;
            wcnt  <= (state == ACCESS && !abort && !last_acc) ? wcnt + 1'b1 : '0;
            if (start_ok) begin
                base <= cfg_base_addr;
                num  <= cfg_num_reads;
                idx  <= '0;
                lane <= '0;
            end else if (last_acc) begin
                idx  <= idx + 1'b1;
                lane <= lane == LW'(PACK - 1) ? '0 : lane + 1'b1;
            end
        end
    end

    rom_lane_packer #(
        .W  (ROM_DATA_WIDTH),
        .P  (PACK),
        .LW (LW)
    ) u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_ok || push_ok),
        .capture (last_acc),
        .lane    (lane),
        .data    (rom_rd_data),
        .word    (pack_word)
    );

    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign fifo_push    = push_ok;
    assign fifo_data_in = push_ok ? FIFO_DATA_WIDTH'(pack_word) : '0;
    assign rom_rd_addr  = state == ACCESS ? base + idx : '0;
    assign CE_bar       = state != ACCESS;
    assign OE_bar       = state != ACCESS;
    assign WE_bar       = 1'b1;

`ifdef ROM_DMA_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n || start_ok)
            stall_cnt <= '0;
        else if (state == PUSH && fifo_full && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_rom_pack_dma.sv
// tb_rom_pack_dma: scoreboard bench for rom_pack_dma with a combinational ROM model.
module tb_rom_pack_dma;

    logic        clk = 0, reset_n = 0, start = 0, abort = 0, fifo_full = 0;
    logic [15:0] cfg_base_addr = '0, cfg_num_reads = '0;
    logic        busy, done, fifo_push, CE_bar, OE_bar, WE_bar;
    logic [31:0] fifo_data_in;
    logic [15:0] rom_rd_addr;
    logic [7:0]  rom_rd_data;
`ifdef ROM_DMA_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0, passed = 0, cyc = 0;
    int push_cnt, done_cnt, push_cyc, done_cyc, first_acc;
    logic [31:0] exp_q[$];
    logic [15:0] acc_q[$];

    rom_pack_dma dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_reads (cfg_num_reads),
        .busy          (busy),
        .done          (done),
        .fifo_data_in  (fifo_data_in),
        .fifo_push     (fifo_push),
        .fifo_full     (fifo_full),
`ifdef ROM_DMA_PERF_EN
        .stall_cnt     (stall_cnt),
`endif
        .rom_rd_addr   (rom_rd_addr),
        .CE_bar        (CE_bar),
        .OE_bar        (OE_bar),
        .WE_bar        (WE_bar),
        .rom_rd_data   (rom_rd_data)
    );

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
    endfunction

    assign rom_rd_data = rom_val(rom_rd_addr);

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic ctrl_ok;
        logic [31:0] e;
        ctrl_ok = CE_bar === 1'b0 ? (OE_bar === 1'b0 && WE_bar === 1'b1)
                                  : (CE_bar === 1'b1 && OE_bar === 1'b1 && WE_bar === 1'b1 && rom_rd_addr === 16'h0);
        checks++;
        if (!ctrl_ok) $display("FAIL rom_ctrl cyc=%0d got CE/OE/WE=%b%b%b addr=%h", cyc, CE_bar, OE_bar, WE_bar, rom_rd_addr);
        else passed++;
        if (fifo_push !== 1'b1) begin
            checks++;
            if (fifo_data_in !== 32'h0) $display("FAIL idle_data cyc=%0d got=%h exp=0", cyc, fifo_data_in);
            else passed++;
        end else begin
            push_cnt++;
            push_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) $display("FAIL unexpected_push cyc=%0d got=%h exp=none", cyc, fifo_data_in);
            else begin
                e = exp_q.pop_front();
                if (fifo_data_in !== e) $display("FAIL push_data cyc=%0d got=%h exp=%h", cyc, fifo_data_in, e);
                else passed++;
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (CE_bar === 1'b0) begin
            if (acc_q.size() == 0) first_acc = cyc;
            acc_q.push_back(rom_rd_addr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats;
        exp_q.delete();
        acc_q.delete();
        push_cnt = 0; done_cnt = 0; push_cyc = -1; done_cyc = -1; first_acc = -1;
    endtask

    task automatic launch(input logic [15:0] b, input logic [15:0] n, input bit expect_words, output int s0);
        logic [31:0] w;
        tick;
        cfg_base_addr = b;
        cfg_num_reads = n;
        start = 1;
        s0 = cyc;
        w = '0;
        if (expect_words)
            for (int i = 0; i < int'(n); i++) begin
                w[8*(i%4) +: 8] = rom_val(b + 16'(i));
                if (i % 4 == 3 || i == int'(n) - 1) begin
                    exp_q.push_back(w);
                    w = '0;
                end
            end
        tick;
        start = 0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            tick;
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 0;
        tick; tick;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        checks++; if (fifo_push !== 1'b0) $display("FAIL reset_push got=%b exp=0", fifo_push); else passed++;
        checks++; if ({CE_bar, OE_bar, WE_bar} !== 3'b111) $display("FAIL reset_ctrl got=%b exp=111", {CE_bar, OE_bar, WE_bar}); else passed++;
        checks++; if (rom_rd_addr !== 16'h0) $display("FAIL reset_addr got=%h exp=0", rom_rd_addr); else passed++;
`ifdef ROM_DMA_PERF_EN
        checks++; if (stall_cnt !== 16'h0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else passed++;
`endif
        reset_n = 1;
        tick;
    endtask

    task automatic test_basic;
        int s0;
        bit ok;
        clear_stats();
        launch(16'h0010, 16'd4, 1, s0);
        wait_idle(200, ok);
        checks++; if (!ok) $display("FAIL basic_timeout got=busy exp=idle"); else passed++;
        checks++; if (acc_q.size() != 32) $display("FAIL basic_acc_len got=%0d exp=32", acc_q.size()); else passed++;
        for (int i = 0; i < 32 && i < acc_q.size(); i += 8) begin
            checks++;
            if (acc_q[i] !== 16'h10 + 16'(i/8) || acc_q[i+7] !== 16'h10 + 16'(i/8))
                $display("FAIL basic_addr i=%0d got=%h/%h exp=%h", i, acc_q[i], acc_q[i+7], 16'h10 + 16'(i/8));
            else passed++;
        end
        checks++; if (first_acc - s0 != 1) $display("FAIL basic_first_acc got=%0d exp=1", first_acc - s0); else passed++;
        checks++; if (push_cnt != 1 || push_cyc - s0 != 33) $display("FAIL basic_push got=%0d@%0d exp=1@33", push_cnt, push_cyc - s0); else passed++;
        checks++; if (done_cnt != 1 || done_cyc - s0 != 34) $display("FAIL basic_done got=%0d@%0d exp=1@34", done_cnt, done_cyc - s0); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL basic_sb_left got=%0d exp=0", exp_q.size()); else passed++;
    endtask

    task automatic test_partial;
        int s0;
        bit ok;
        clear_stats();
        launch(16'h0040, 16'd6, 1, s0);
        wait_idle(300, ok);
        checks++; if (!ok) $display("FAIL partial_timeout got=busy exp=idle"); else passed++;
        checks++; if (push_cnt != 2) $display("FAIL partial_pushes got=%0d exp=2", push_cnt); else passed++;
        checks++; if (done_cnt != 1 || done_cyc - s0 != 51) $display("FAIL partial_done got=%0d@%0d exp=1@51", done_cnt, done_cyc - s0); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL partial_sb_left got=%0d exp=0", exp_q.size()); else passed++;
    endtask

    task automatic test_stall;
        int s0;
        bit ok;
        clear_stats();
        fifo_full = 1;
        launch(16'h0100, 16'd4, 1, s0);
        while (cyc - s0 < 38) tick;
        checks++; if (push_cnt != 0 || busy !== 1'b1) $display("FAIL stall_held got=%0d pushes busy=%b exp=0 busy=1", push_cnt, busy); else passed++;
        fifo_full = 0;
        wait_idle(200, ok);
        checks++; if (!ok) $display("FAIL stall_timeout got=busy exp=idle"); else passed++;
        checks++; if (push_cnt != 1 || push_cyc - s0 != 38) $display("FAIL stall_push got=%0d@%0d exp=1@38", push_cnt, push_cyc - s0); else passed++;
        checks++; if (done_cyc - s0 != 39) $display("FAIL stall_done got=%0d exp=39", done_cyc - s0); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL stall_sb_left got=%0d exp=0", exp_q.size()); else passed++;
`ifdef ROM_DMA_PERF_EN
        checks++; if (stall_cnt !== 16'd5) $display("FAIL stall_cnt got=%0d exp=5", stall_cnt); else passed++;
`endif
    endtask

    task automatic test_wrap;
        int s0;
        bit ok;
        logic [15:0] exp_a[4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        clear_stats();
        launch(16'hFFFE, 16'd4, 1, s0);
        wait_idle(200, ok);
        checks++; if (!ok || acc_q.size() != 32) $display("FAIL wrap_len got=%0d exp=32", acc_q.size()); else passed++;
        for (int i = 0; i < 4 && acc_q.size() == 32; i++) begin
            checks++;
            if (acc_q[i*8] !== exp_a[i]) $display("FAIL wrap_addr i=%0d got=%h exp=%h", i, acc_q[i*8], exp_a[i]);
            else passed++;
        end
        checks++; if (exp_q.size() != 0 || push_cnt != 1) $display("FAIL wrap_push got=%0d exp=1", push_cnt); else passed++;
    endtask

    task automatic test_abort;
        int s0;
        bit ok;
        clear_stats();
        launch(16'h0080, 16'd8, 0, s0);
        while (cyc - s0 < 11) tick;
        abort = 1;
        tick;
        abort = 0;
        checks++; if (busy !== 1'b0 || CE_bar !== 1'b1) $display("FAIL abort_idle got busy=%b CE=%b exp busy=0 CE=1", busy, CE_bar); else passed++;
        repeat (40) tick;
        checks++; if (push_cnt != 0 || done_cnt != 0) $display("FAIL abort_quiet got push=%0d done=%0d exp=0/0", push_cnt, done_cnt); else passed++;
        checks++; if (acc_q.size() != 11) $display("FAIL abort_acc_len got=%0d exp=11", acc_q.size()); else passed++;
        start = 1;
        abort = 1;
        tick;
        start = 0;
        abort = 0;
        checks++; if (busy !== 1'b0) $display("FAIL start_abort got busy=%b exp=0", busy); else passed++;
        clear_stats();
        launch(16'h1234, 16'd0, 1, s0);
        wait_idle(20, ok);
        checks++; if (!ok || done_cnt != 1 || done_cyc - s0 != 1) $display("FAIL zero_done got=%0d@%0d exp=1@1", done_cnt, done_cyc - s0); else passed++;
        checks++; if (acc_q.size() != 0 || push_cnt != 0) $display("FAIL zero_quiet got acc=%0d push=%0d exp=0/0", acc_q.size(), push_cnt); else passed++;
    endtask

    task automatic test_reset_mid;
        int s0;
        clear_stats();
        launch(16'h0200, 16'd4, 0, s0);
        while (cyc - s0 < 20) tick;
        reset_n = 0;
        tick;
        checks++; if (busy !== 1'b0 || CE_bar !== 1'b1) $display("FAIL midreset_idle got busy=%b CE=%b exp busy=0 CE=1", busy, CE_bar); else passed++;
        reset_n = 1;
        repeat (40) tick;
        checks++; if (push_cnt != 0 || done_cnt != 0) $display("FAIL midreset_quiet got push=%0d done=%0d exp=0/0", push_cnt, done_cnt); else passed++;
    endtask

    task automatic test_back_to_back;
        int s0;
        bit ok;
        clear_stats();
        launch(16'h0020, 16'd3, 1, s0);
        while (cyc - s0 < 10) tick;
        cfg_base_addr = 16'h0090;
        cfg_num_reads = 16'd7;
        start = 1;
        tick;
        start = 0;
        wait_idle(300, ok);
        checks++; if (!ok) $display("FAIL busy_start_timeout got=busy exp=idle"); else passed++;
        checks++; if (push_cnt != 1 || done_cnt != 1) $display("FAIL busy_start_counts got push=%0d done=%0d exp=1/1", push_cnt, done_cnt); else passed++;
        checks++; if (acc_q.size() != 24) $display("FAIL busy_start_acc_len got=%0d exp=24", acc_q.size()); else passed++;
        checks++; if (acc_q.size() == 24 && (acc_q[0] !== 16'h20 || acc_q[23] !== 16'h22)) $display("FAIL busy_start_addr got=%h..%h exp=0020..0022", acc_q[0], acc_q[23]); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL busy_start_sb_left got=%0d exp=0", exp_q.size()); else passed++;
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_basic();
        test_partial();
        test_stall();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
